capture_readout: RTL
====================

Name: capture_readout

Overview:
- Reads back a completed capture from the sample RAM once the capture has finished (Write_Ready high).
- Starts from a programmed pre-trigger offset relative to the trigger address and streams Read_Len sample pairs (channel A/B) to the MCU bus interface, one sample per Read_Req strobe.
- Sits between the sample RAM read port and the MCU register interface. It is the consumer side of the Synchronization/WIN_Counter write path.

Parameters:
- ADDR_W, 18, RAM address and length counter width; addresses wrap modulo 2^ADDR_W.
- RAM_LAT, 1, cycles from RAM_RD to valid RAM_DATA_A/B; legal range 1..3.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- Write_Ready  in  1  capture complete (level from Synchronization)
- Trig_Addr  in  ADDR_W  RAM address of the trigger sample
- Pre_Trig  in  ADDR_W  samples to output before the trigger sample
- Read_Len  in  ADDR_W  total samples to output
- Read_Start  in  1  one-cycle pulse, begin readout
- Read_Req  in  1  one-cycle pulse, consumer took current sample
- RAM_DATA_A  in  8  RAM read data, channel A
- RAM_DATA_B  in  8  RAM read data, channel B
- RAM_Addr  out  ADDR_W  RAM read address
- RAM_RD  out  1  RAM read strobe, one cycle per sample
- DATA_OUT_A  out  8  held sample, channel A
- DATA_OUT_B  out  8  held sample, channel B
- Data_Valid  out  1  DATA_OUT_A/B valid
- Busy  out  1  readout in progress
- Read_Done  out  1  all Read_Len samples consumed (level)

Behaviour:
- Reset: all outputs 0; state IDLE; internal address and remaining counters 0.
- States: IDLE, WAIT_WR, LOAD, FETCH, WAIT_RAM, HOLD, DONE.
- IDLE/DONE + Read_Start:
  - Write_Ready=1 → LOAD.
  - Write_Ready=0 → WAIT_WR.
  - Entering either clears Read_Done.
  - Read_Start in any other state is ignored.
- WAIT_WR: stays until Write_Ready=1, then LOAD. Busy=1.
- LOAD (one cycle):
  - addr = (Trig_Addr − Pre_Trig) mod 2^ADDR_W.
  - remaining = Read_Len.
  - Read_Len=0 → DONE directly; RAM_RD is never asserted.
- FETCH (one cycle): RAM_RD=1, RAM_Addr=addr → WAIT_RAM.
- WAIT_RAM:
  - Counts RAM_LAT cycles.
  - On the last one, registers RAM_DATA_A/B into DATA_OUT_A/B, sets Data_Valid=1 → HOLD.
- HOLD:
  - Data_Valid=1 and DATA_OUT stable until Read_Req.
  - On Read_Req: Data_Valid=0 next edge; addr+1 (2^ADDR_W−1 wraps to 0); remaining−1.
  - If remaining becomes 0 → DONE, else → FETCH.
- DONE: Read_Done=1, Busy=0, Data_Valid=0; held until Read_Start or RST.
- Read_Req while Data_Valid=0 is ignored; there is no queuing.
- Busy=1 in WAIT_WR, LOAD, FETCH, WAIT_RAM, HOLD.
- Latency:
  - Read_Start sampled at edge k with Write_Ready=1: RAM_RD high during cycle k+2, Data_Valid rises at edge k+2+RAM_LAT.
  - Read_Req sampled at edge j: next Data_Valid at edge j+1+RAM_LAT.
- Write_Ready falling while Busy (new capture started):
  - Abort to IDLE at the next edge.
  - Busy=0, Data_Valid=0, Read_Done=0, RAM_RD=0.
  - DATA_OUT retains its last value.
- RST mid-readout returns to reset values at the next edge.
- RAM_RD is never asserted outside FETCH.

Optional Feature:
- Macro: READOUT_CHECKSUM_EN.
- Defined:
  - Adds output Checksum (8 bit).
  - Cleared in LOAD.
  - On each accepted Read_Req: Checksum = Checksum + DATA_OUT_A + DATA_OUT_B, mod 256.
  - Final value is valid while Read_Done=1.
- Undefined: no Checksum port and no adder logic; all other behaviour is identical.

Test Plan:
- Basic read: Trig_Addr=100, Pre_Trig=10, Read_Len=4, RAM data = address low byte on A, inverted on B, Read_Req each time Data_Valid rises → RAM_Addr 90,91,92,93; DATA_OUT_A 0x5A..0x5D; Read_Done=1 after the 4th Read_Req; Data_Valid first rises at edge k+3 (RAM_LAT=1).
- Wrap: Trig_Addr=2, Pre_Trig=5, Read_Len=6 (ADDR_W=18) → addresses 0x3FFFD,0x3FFFE,0x3FFFF,0,1,2.
- Read_Len=0 → RAM_RD never asserted; Read_Done=1 two cycles after Read_Start; Busy drops with Read_Done.
- Read_Start with Write_Ready=0 → WAIT_WR, Busy=1, no RAM_RD; raise Write_Ready 20 cycles later → readout proceeds normally. Extra Read_Req pulses while Data_Valid=0 do not advance the address.
- Abort: drop Write_Ready in HOLD after 2 of 8 samples → IDLE next edge; Busy=0, Data_Valid=0, Read_Done=0. Repeat with RST instead → all outputs 0.
- RAM_LAT=3, READOUT_CHECKSUM_EN defined, 3 samples A=0x10/B=0x01, A=0x20/B=0x02, A=0xF0/B=0x0F → Data_Valid 4 cycles after each Read_Req; Checksum=0x32 at Read_Done.

Source files
------------

// File: rtl/capture_readout.sv
// Streams a finished capture from the sample RAM to the MCU bus, starting Pre_Trig samples before the trigger.
// Optional macro READOUT_CHECKSUM_EN adds an 8-bit running checksum output of the consumed samples.
module capture_readout #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Write_Ready,
  input  logic [ADDR_W-1:0] Trig_Addr,
  input  logic [ADDR_W-1:0] Pre_Trig,
  input  logic [ADDR_W-1:0] Read_Len,
  input  logic              Read_Start,
  input  logic              Read_Req,
  input  logic [7:0]        RAM_DATA_A,
  input  logic [7:0]        RAM_DATA_B,
  output logic [ADDR_W-1:0] RAM_Addr,
  output logic              RAM_RD,
  output logic [7:0]        DATA_OUT_A,
  output logic [7:0]        DATA_OUT_B,
  output logic              Data_Valid,
  output logic              Busy,
`ifdef READOUT_CHECKSUM_EN
  output logic [7:0]        Checksum,
`endif
  output logic              Read_Done
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_WR, S_LOAD, S_FETCH, S_WAIT_RAM, S_HOLD, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [1:0]        lat_q, lat_d;
  logic [7:0]        data_a_q, data_a_d, data_b_q, data_b_d;
  logic              ram_rd_q, ram_rd_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    lat_d    = lat_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Read_Start) state_d = Write_Ready ? S_LOAD : S_WAIT_WR;
      end
      S_WAIT_WR: begin
        if (Write_Ready) state_d = S_LOAD;
      end
      S_LOAD: begin
        addr_d   = Trig_Addr - Pre_Trig;
        remain_d = Read_Len;
        state_d  = (Read_Len == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        lat_d   = '0;
        state_d = S_WAIT_RAM;
      end
      S_WAIT_RAM: begin
        if (lat_q == 2'(RAM_LAT - 1)) begin
          data_a_d = RAM_DATA_A;
          data_b_d = RAM_DATA_B;
          state_d  = S_HOLD;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_HOLD: begin
        if (Read_Req) begin
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - ADDR_W'(1);
          state_d  = (remain_q == ADDR_W'(1)) ? S_DONE : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new capture overwrites the RAM under us: abandon, keep the last shown sample
    if (!Write_Ready && (state_q inside {S_LOAD, S_FETCH, S_WAIT_RAM, S_HOLD})) begin
      state_d  = S_IDLE;
      data_a_d = data_a_q;
      data_b_d = data_b_q;
    end

    ram_rd_d   = (state_d == S_FETCH);
    ram_addr_d = (state_d == S_FETCH) ? addr_d : ram_addr_q;
    valid_d    = (state_d == S_HOLD);
    busy_d     = (state_d inside {S_WAIT_WR, S_LOAD, S_FETCH, S_WAIT_RAM, S_HOLD});
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      ram_addr_q <= '0;
      lat_q      <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      ram_rd_q   <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      ram_addr_q <= ram_addr_d;
      lat_q      <= lat_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      ram_rd_q   <= ram_rd_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign RAM_Addr   = ram_addr_q;
  assign RAM_RD     = ram_rd_q;
  assign DATA_OUT_A = data_a_q;
  assign DATA_OUT_B = data_b_q;
  assign Data_Valid = valid_q;
  assign Busy       = busy_q;
  assign Read_Done  = done_q;

`ifdef READOUT_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;
  logic       accept_c;

  // Sum of both channels of every sample the consumer actually took
  always_comb begin
    accept_c   = (state_q == S_HOLD) && Read_Req && Write_Ready;
    checksum_d = checksum_q;
    if (state_q == S_LOAD)  checksum_d = '0;
    else if (accept_c)      checksum_d = checksum_q + data_a_q + data_b_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) checksum_q <= '0;
    else     checksum_q <= checksum_d;
  end

  assign Checksum = checksum_q;
`else
  // Checksum hardware not built
`endif

endmodule
